// File: rtl/pc_fetch_ctrl.sv
// Fetch controller for program_counter: reset vector, increment, redirect.
// One imem fetch in flight; instruction handed to decode on valid/ready.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_IN,
  output logic [31:0] NEXT_PC,
  output logic        W_PC,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY
);

  typedef enum logic [1:0] {
    S_INIT,
    S_FETCH,
    S_DRAIN,
    S_VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        w_pc;
  logic        req;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_INIT;
      instr_q    <= '0;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    req_addr_d = req_addr_q;
    w_pc       = 1'b0;
    NEXT_PC    = PC_IN;
    req        = 1'b0;
    IMEM_ADDR  = PC_IN;
    unique case (state_q)
      S_INIT: begin
        w_pc    = 1'b1;
        NEXT_PC = RESET_PC;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        req        = 1'b1;
        req_addr_d = PC_IN;
        if (BR_TAKEN) begin
          w_pc    = 1'b1;
          NEXT_PC = BR_TARGET;
          state_d = IMEM_ACK ? S_FETCH : S_DRAIN;
        end else if (IMEM_ACK) begin
          instr_d = IMEM_DATA;
          ipc_d   = PC_IN;
          valid_d = 1'b1;
          w_pc    = 1'b1;
          NEXT_PC = PC_IN + PC_INC;
          state_d = S_VALID;
        end
      end
      // address of the aborted request is held until its ack returns
      S_DRAIN: begin
        req       = 1'b1;
        IMEM_ADDR = req_addr_q;
        if (BR_TAKEN) begin
          w_pc    = 1'b1;
          NEXT_PC = BR_TARGET;
        end
        if (IMEM_ACK) state_d = S_FETCH;
      end
      S_VALID: begin
        if (BR_TAKEN) begin
          w_pc    = 1'b1;
          NEXT_PC = BR_TARGET;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (INSTR_READY) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign W_PC        = w_pc & RST_N;
  assign IMEM_REQ    = req & RST_N;
  assign INSTR       = instr_q;
  assign INSTR_PC    = ipc_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch controller for the program_counter register.
- Drives the PC's `in`/`W_PC` pair: reset vector, sequential increment and branch redirect.
- Reads the current PC value to fetch one instruction from instruction memory over a req/ack handshake.
- Presents the instruction to decode over a valid/ready handshake, with one fetch in flight.

Parameters:
- RESET_PC, 32'h0000_0000: vector loaded into the PC after reset.
- PC_INC, 1: increment per sequential fetch; PC is word-addressed.

Ports:
- CLK  in  1  rising-edge clock, shared with program_counter.
- RST_N  in  1  asynchronous active-low reset.
- PC_IN  in  32  current PC, from program_counter `out`.
- NEXT_PC  out  32  value for program_counter `in`.
- W_PC  out  1  write enable for program_counter.
- BR_TAKEN  in  1  redirect request from execute, single-cycle pulse.
- BR_TARGET  in  32  redirect address, valid when BR_TAKEN=1.
- IMEM_REQ  out  1  instruction-memory read request.
- IMEM_ADDR  out  32  read address; stable while IMEM_REQ=1.
- IMEM_ACK  in  1  data valid on IMEM_DATA this cycle.
- IMEM_DATA  in  32  instruction word.
- INSTR  out  32  fetched instruction.
- INSTR_PC  out  32  address of INSTR.
- INSTR_VALID  out  1  INSTR/INSTR_PC valid.
- INSTR_READY  in  1  decode accepts INSTR.

Behaviour:
- **FSM states:** INIT, FETCH, DRAIN, VALID. All registers are reset asynchronously by RST_N=0.
- **Reset values:**
  - state=INIT.
  - INSTR=0, INSTR_PC=0, INSTR_VALID=0, req_addr=0.
  - W_PC=0 and IMEM_REQ=0 while RST_N=0.
- **NEXT_PC/W_PC:** combinational from state and inputs; program_counter samples them at the next CLK edge.
- **INIT:**
  - W_PC=1, NEXT_PC=RESET_PC, IMEM_REQ=0.
  - Next state FETCH. BR_TAKEN is ignored.
- **FETCH:**
  - IMEM_REQ=1, IMEM_ADDR=PC_IN; req_addr<=PC_IN every cycle.
  - ACK=1, BR_TAKEN=0: INSTR<=IMEM_DATA, INSTR_PC<=PC_IN, INSTR_VALID<=1. W_PC=1 with NEXT_PC=PC_IN+PC_INC (mod 2^32, 32'hFFFF_FFFF+1 wraps to 0). Next state VALID.
  - ACK=1, BR_TAKEN=1: data discarded. W_PC=1 with NEXT_PC=BR_TARGET. Stay in FETCH.
  - ACK=0, BR_TAKEN=1: W_PC=1 with NEXT_PC=BR_TARGET. Next state DRAIN.
  - ACK=0, BR_TAKEN=0: hold, W_PC=0.
- **DRAIN** (the outstanding request must complete):
  - IMEM_REQ=1, IMEM_ADDR=req_addr (unchanged from the aborted request).
  - BR_TAKEN=1: W_PC=1 with NEXT_PC=BR_TARGET; the last redirect wins.
  - ACK=1: data discarded, next state FETCH.
  - INSTR_VALID stays 0.
- **VALID:**
  - INSTR_VALID=1, IMEM_REQ=0; INSTR and INSTR_PC are held stable until accepted.
  - INSTR_READY=1: INSTR_VALID<=0, next state FETCH.
  - BR_TAKEN=1, regardless of READY: INSTR_VALID<=0, W_PC=1 with NEXT_PC=BR_TARGET, next state FETCH. If READY was also 1, the instruction counts as consumed.
- **Latency/throughput:**
  - ACK in cycle N gives INSTR_VALID=1 in cycle N+1.
  - With zero-wait memory and READY tied high, one instruction every 2 cycles.
- **Reset mid-operation:**
  - Immediate return to INIT, INSTR_VALID=0, IMEM_REQ=0.
  - A pending IMEM_ACK after reset release is ignored in INIT.
- **Protocol rules:**
  - IMEM_ADDR never changes while IMEM_REQ=1 without an intervening ACK or redirect-into-DRAIN.
  - INSTR never changes while INSTR_VALID=1.

Test Plan:
1. **Reset vector:** RST_N low 2 cycles then high, RESET_PC=0 -> W_PC=1, NEXT_PC=0 for one cycle; then IMEM_REQ=1, IMEM_ADDR=0.
2. **Sequential fetch:** zero-wait memory returns 32'hA0+addr, READY=1 -> INSTR_PC sequence 0,1,2,3 with INSTR 32'hA0..32'hA3; INSTR_VALID high every 2nd cycle; W_PC pulse with NEXT_PC=INSTR_PC+1 on each ACK.
3. **Wait states:** ACK delayed 3 cycles at PC=4 -> IMEM_REQ=1 and IMEM_ADDR=4 stable for 4 cycles; W_PC=0 until ACK; INSTR=32'hA4.
4. **Decode backpressure:** READY=0 for 5 cycles with INSTR_PC=2 -> INSTR_VALID stays 1, INSTR/INSTR_PC unchanged, IMEM_REQ=0; accept on READY=1, next fetch at 3.
5. **Redirects:**
   - BR_TAKEN, BR_TARGET=32'h40 during pending fetch at 5 (ACK 2 cycles later) -> DRAIN holds IMEM_ADDR=5, data discarded, INSTR_VALID never asserted for 5, next fetch IMEM_ADDR=32'h40.
   - BR_TAKEN in VALID with READY=0 -> INSTR_VALID drops next cycle, PC=target.
6. **Wrap and reset:**
   - PC=32'hFFFF_FFFF fetch -> NEXT_PC=0.
   - RST_N pulsed low in VALID -> INSTR_VALID=0, IMEM_REQ=0 immediately, refetch from RESET_PC.
